// File: rtl/lfsr_seq_pkg.sv
// Shared constants and FSM state type for the LFSR word sequencer.
// Imported by lfsr_core and lfsr_word_sequencer.
package lfsr_seq_pkg;

    localparam int LFSR_W_DEF    = 18;
    localparam int TAP_HI_DEF    = 18;
    localparam int TAP_LO_DEF    = 11;
    localparam int WORD_BITS_DEF = 16;
    localparam int CNT_W         = 6;
    localparam int STATE_W       = 2;

    localparam logic [LFSR_W_DEF-1:0] SEED_DEFAULT_DEF = 18'h3FFFF;

    typedef enum logic [STATE_W-1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        HOLD  = 2'd2
    } seq_state_t;

endpackage

// File: rtl/lfsr_word_sequencer_if.sv
// Word delivery handshake between the sequencer (master) and a consumer.
// The master holds word/word_valid stable until word_ready is seen.
interface lfsr_word_sequencer_if #(
    parameter int WORD_BITS = 16
) ();

    logic [WORD_BITS-1:0] word;
    logic                 word_valid;
    logic                 word_ready;

    modport master (
        output word,
        output word_valid,
        input  word_ready
    );

    modport slave (
        input  word,
        input  word_valid,
        output word_ready
    );

endinterface

// File: rtl/lfsr_core.sv
// Fibonacci LFSR register: step enable, synchronous load with
// all-zero seed substitution, serial output from the TAP_HI stage.
module lfsr_core
    import lfsr_seq_pkg::*;
#(
    parameter int              LFSR_W = LFSR_W_DEF,
    parameter int              TAP_HI = TAP_HI_DEF,
    parameter int              TAP_LO = TAP_LO_DEF,
    parameter logic [LFSR_W-1:0] SEED = SEED_DEFAULT_DEF
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_step,
    input  logic              i_load,
    input  logic [LFSR_W-1:0] i_seed,
    output logic [LFSR_W-1:0] o_state,
    output logic              o_bit
);

    logic [LFSR_W-1:0] r_state;
    logic              w_fb;
    logic [LFSR_W-1:0] w_seed;

    // Stage k lives at bit k-1.
    assign w_fb    = r_state[TAP_HI-1] ^ r_state[TAP_LO-1];
    assign w_seed  = (i_seed == '0) ? SEED : i_seed;
    assign o_state = r_state;
    assign o_bit   = r_state[TAP_HI-1];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= SEED;
        end else if (i_load) begin
            r_state <= w_seed;
        end else if (i_step) begin
            r_state <= {r_state[LFSR_W-2:0], w_fb};
        end
    end

endmodule

// File: rtl/lfsr_word_sequencer.sv
// LFSR word sequencer: packs WORD_BITS serial LFSR bits per word.
// Optional period checker enabled by defining LFSR_PERIOD_CHECK_EN.
module lfsr_word_sequencer
    import lfsr_seq_pkg::*;
#(
    parameter int                LFSR_W       = LFSR_W_DEF,
    parameter int                TAP_HI       = TAP_HI_DEF,
    parameter int                TAP_LO       = TAP_LO_DEF,
    parameter int                WORD_BITS    = WORD_BITS_DEF,
    parameter logic [LFSR_W-1:0] SEED_DEFAULT = SEED_DEFAULT_DEF
) (
    input  logic                i_clock,
    input  logic                i_clear,
    input  logic                i_run,
    input  logic                i_seed_load,
    input  logic [LFSR_W-1:0]   i_seed,
    output logic                o_load_rejected,
    output logic                o_busy,
    output logic [LFSR_W-1:0]   o_lfsr_state,
`ifdef LFSR_PERIOD_CHECK_EN
    output logic                o_period_wrap,
    output logic                o_period_err,
`endif
    lfsr_word_sequencer_if.master m_word
);

    seq_state_t           r_state;
    seq_state_t           w_state_nxt;
    logic [CNT_W-1:0]     r_cnt;
    logic [CNT_W-1:0]     w_cnt_nxt;
    logic [WORD_BITS-1:0] r_shreg;
    logic [WORD_BITS-1:0] r_word;
    logic                 r_valid;
    logic                 r_rej;
    logic                 w_step;
    logic                 w_load;
    logic                 w_done;
    logic                 w_accept;
    logic                 w_bit;
    logic [LFSR_W-1:0]    w_lfsr;

    lfsr_core #(
        .LFSR_W (LFSR_W),
        .TAP_HI (TAP_HI),
        .TAP_LO (TAP_LO),
        .SEED   (SEED_DEFAULT)
    ) u_core (
        .i_clk   (i_clock),
        .i_rst   (i_clear),
        .i_step  (w_step),
        .i_load  (w_load),
        .i_seed  (i_seed),
        .o_state (w_lfsr),
        .o_bit   (w_bit)
    );

    // SHIFT spends WORD_BITS step cycles plus one cycle to publish the word.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_step      = 1'b0;
        w_load      = 1'b0;
        w_done      = 1'b0;
        w_accept    = 1'b0;
        unique case (r_state)
            IDLE: begin
                w_load = i_seed_load;
                if (i_run) begin
                    w_state_nxt = SHIFT;
                    w_cnt_nxt   = '0;
                end
            end
            SHIFT: begin
                if (r_cnt == CNT_W'(WORD_BITS)) begin
                    w_done      = 1'b1;
                    w_state_nxt = HOLD;
                end else begin
                    w_step    = 1'b1;
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            HOLD: begin
                if (m_word.word_ready) begin
                    w_accept    = 1'b1;
                    w_state_nxt = i_run ? SHIFT : IDLE;
                    w_cnt_nxt   = '0;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (i_clear) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_shreg <= '0;
            r_word  <= '0;
            r_valid <= 1'b0;
            r_rej   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_rej   <= i_seed_load && (r_state != IDLE);
            if (w_step) begin
                r_shreg <= (r_shreg << 1) | WORD_BITS'(w_bit);
            end
            if (w_done) begin
                r_word  <= r_shreg;
                r_valid <= 1'b1;
            end else if (w_accept) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign m_word.word       = r_word;
    assign m_word.word_valid = r_valid;
    assign o_load_rejected   = r_rej;
    assign o_busy            = (r_state != IDLE);
    assign o_lfsr_state      = w_lfsr;

`ifdef LFSR_PERIOD_CHECK_EN
    logic [LFSR_W-1:0] r_pcnt;
    logic [LFSR_W-1:0] r_ref;
    logic              r_wrap;
    logic              r_err;
    logic [LFSR_W-1:0] w_pcnt_inc;
    logic [LFSR_W-1:0] w_next;

    assign w_pcnt_inc = r_pcnt + 1'b1;
    assign w_next     = {w_lfsr[LFSR_W-2:0],
                         w_lfsr[TAP_HI-1] ^ w_lfsr[TAP_LO-1]};

    // A full maximal-length cycle returns after exactly 2^LFSR_W-1 steps.
    always_ff @(posedge i_clock) begin
        if (i_clear) begin
            r_pcnt <= '0;
            r_ref  <= SEED_DEFAULT;
            r_wrap <= 1'b0;
            r_err  <= 1'b0;
        end else begin
            r_wrap <= 1'b0;
            if (w_load) begin
                r_pcnt <= '0;
                r_ref  <= (i_seed == '0) ? SEED_DEFAULT : i_seed;
            end else if (w_step) begin
                if (w_next == r_ref) begin
                    r_wrap <= 1'b1;
                    r_pcnt <= '0;
                    if (w_pcnt_inc != '1) begin
                        r_err <= 1'b1;
                    end
                end else begin
                    r_pcnt <= w_pcnt_inc;
                end
            end
        end
    end

    assign o_period_wrap = r_wrap;
    assign o_period_err  = r_err;
`endif

endmodule

// File: tb/tb_lfsr_word_sequencer.sv
// Directed self-checking bench for lfsr_word_sequencer.
// Expected words and LFSR states are hand-derived from taps 18/11.
module tb_lfsr_word_sequencer;

    logic        clk;
    logic        clear;
    logic        run;
    logic        seed_load;
    logic [17:0] seed;
    logic        load_rejected;
    logic        busy;
    logic [17:0] lfsr_state;
`ifdef LFSR_PERIOD_CHECK_EN
    logic        period_wrap;
    logic        period_err;
`endif

    int checks   = 0;
    int failures = 0;

    lfsr_word_sequencer_if #(.WORD_BITS(16)) u_if ();

    lfsr_word_sequencer dut (
        .i_clock         (clk),
        .i_clear         (clear),
        .i_run           (run),
        .i_seed_load     (seed_load),
        .i_seed          (seed),
        .o_load_rejected (load_rejected),
        .o_busy          (busy),
        .o_lfsr_state    (lfsr_state),
`ifdef LFSR_PERIOD_CHECK_EN
        .o_period_wrap   (period_wrap),
        .o_period_err    (period_err),
`endif
        .m_word          (u_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag,
                         input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        clear = 1'b1;
        run = 1'b0;
        seed_load = 1'b0;
        seed = '0;
        u_if.word_ready = 1'b0;
        tick();
        tick();
        check("rst_lfsr", 32'(lfsr_state), 32'h3FFFF);
        check("rst_valid", 32'(u_if.word_valid), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_word", 32'(u_if.word), 32'h0);
        check("rst_rej", 32'(load_rejected), 32'h0);
        clear = 1'b0;

        // First word from the default seed.
        run = 1'b1;
        tick();
        check("w1_busy", 32'(busy), 32'h1);
        check("w1_valid_early", 32'(u_if.word_valid), 32'h0);
        repeat (16) tick();
        check("w1_valid_t16", 32'(u_if.word_valid), 32'h0);
        tick();
        check("w1_valid", 32'(u_if.word_valid), 32'h1);
        check("w1_word", 32'(u_if.word), 32'hFFFF);
        check("w1_lfsr", 32'(lfsr_state), 32'h3001F);

        // Back-pressure: everything frozen while ready is low.
        for (int i = 0; i < 10; i++) begin
            tick();
            check("hold_word", 32'(u_if.word), 32'hFFFF);
            check("hold_valid", 32'(u_if.word_valid), 32'h1);
            check("hold_lfsr", 32'(lfsr_state), 32'h3001F);
        end

        // Handshake with run high, rejected load during SHIFT.
        u_if.word_ready = 1'b1;
        tick();
        check("hs_valid", 32'(u_if.word_valid), 32'h0);
        check("hs_busy", 32'(busy), 32'h1);
        u_if.word_ready = 1'b0;
        seed_load = 1'b1;
        seed = 18'h12345;
        tick();
        check("shift_rej", 32'(load_rejected), 32'h1);
        seed_load = 1'b0;
        tick();
        check("shift_rej_end", 32'(load_rejected), 32'h0);
        repeat (14) tick();
        check("w2_valid_t16", 32'(u_if.word_valid), 32'h0);
        check("w2_old_word", 32'(u_if.word), 32'hFFFF);
        tick();
        check("w2_valid", 32'(u_if.word_valid), 32'h1);
        check("w2_word", 32'(u_if.word), 32'hC007);
        check("w2_lfsr", 32'(lfsr_state), 32'h3C3FF);

        // Load in HOLD is rejected too.
        seed_load = 1'b1;
        tick();
        check("hold_rej", 32'(load_rejected), 32'h1);
        check("hold_rej_lfsr", 32'(lfsr_state), 32'h3C3FF);
        seed_load = 1'b0;

        // Handshake with run low returns to IDLE.
        run = 1'b0;
        u_if.word_ready = 1'b1;
        tick();
        check("idle_valid", 32'(u_if.word_valid), 32'h0);
        check("idle_busy", 32'(busy), 32'h0);
        tick();
        check("idle_rdy_busy", 32'(busy), 32'h0);
        check("idle_rdy_valid", 32'(u_if.word_valid), 32'h0);
        check("idle_lfsr", 32'(lfsr_state), 32'h3C3FF);
        u_if.word_ready = 1'b0;

        // All-zero seed substitutes the default.
        seed = '0;
        seed_load = 1'b1;
        tick();
        check("zero_seed", 32'(lfsr_state), 32'h3FFFF);
        check("zero_seed_rej", 32'(load_rejected), 32'h0);

        // Load and run together: SHIFT starts from the new seed.
        seed = 18'h00001;
        run = 1'b1;
        tick();
        check("ldrun_lfsr", 32'(lfsr_state), 32'h00001);
        check("ldrun_busy", 32'(busy), 32'h1);
        seed_load = 1'b0;
        repeat (16) tick();
        check("w3_old_word", 32'(u_if.word), 32'hC007);
        tick();
        check("w3_valid", 32'(u_if.word_valid), 32'h1);
        check("w3_word", 32'(u_if.word), 32'h0000);
        check("w3_lfsr", 32'(lfsr_state), 32'h10020);

        // Clear in the middle of a word.
        u_if.word_ready = 1'b1;
        tick();
        check("w4_hs_valid", 32'(u_if.word_valid), 32'h0);
        u_if.word_ready = 1'b0;
        repeat (7) tick();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        run = 1'b0;
        check("clr_busy", 32'(busy), 32'h0);
        check("clr_valid", 32'(u_if.word_valid), 32'h0);
        check("clr_lfsr", 32'(lfsr_state), 32'h3FFFF);
        check("clr_word", 32'(u_if.word), 32'h0);
        tick();
        check("clr_idle_busy", 32'(busy), 32'h0);
        check("clr_idle_lfsr", 32'(lfsr_state), 32'h3FFFF);
`ifdef LFSR_PERIOD_CHECK_EN
        check("per_err", 32'(period_err), 32'h0);
        check("per_wrap", 32'(period_wrap), 32'h0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
